dcpu16_mslave: RTL and testbench

- Memory responder for the two simplified-Wishbone buses driven by the CPU memory-bus initiator: F-BUS (fetch/write-back) and G-BUS (operand reads).
- Single-port word-addressed RAM shared by both buses, with an internal arbiter, programmable wait states and a one-cycle ack pulse per transaction.
- Sits between the CPU core and on-chip memory. Port names match the initiator's, so wiring is name-to-name.

---
 rtl/dcpu16_mslave_pkg.sv | 22 ++
 rtl/dcpu16_spram.sv | 27 ++
 rtl/dcpu16_mslave.sv | 165 ++++++++++++++++
 tb/tb_dcpu16_mslave.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcpu16_mslave_pkg.sv
// Shared definitions for the DCPU-16 memory responder: FSM states and sizing helpers.
package dcpu16_mslave_pkg;

    localparam int DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dcpu16_spram.sv
// Single-port synchronous RAM, one access per enabled edge. Kept separate so a
// vendor macro can replace it without touching the responder logic.
module dcpu16_spram #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] adr,
    input  logic [15:0]   din,
    output logic [15:0]   dout
);

    logic [15:0] mem [0:(1 << AW)-1];

    // Write stores din; read registers the addressed word. dout only changes on reads.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[adr] <= din;
            end else begin
                dout <= mem[adr];
            end
        end
    end

endmodule

// File: rtl/dcpu16_mslave.sv
// Memory responder for the CPU F-BUS and G-BUS: round-robin arbiter, wait-state
// FSM, one-cycle ack per transaction, per-bus read-data registers.
module dcpu16_mslave
    import dcpu16_mslave_pkg::*;
#(
    parameter int AW   = 16,
    parameter int WAIT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   f_adr,
    input  logic          f_stb,
    input  logic          f_wre,
    input  logic [15:0]   f_dto,
    output logic [15:0]   f_dti,
    output logic          f_ack,
    input  logic [15:0]   g_adr,
    input  logic          g_stb,
    input  logic          g_wre,
    input  logic [15:0]   g_dto,
    output logic [15:0]   g_dti,
    output logic          g_ack
);

    // Counter holds WAIT-1 at most.
    localparam int CW = (WAIT < 2) ? 1 : clog2(WAIT);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pref_g_q, pref_g_d;   // 1: G wins the next tie
    logic            gnt_g_q, gnt_g_d;     // bus owning the in-flight transaction
    logic            wre_q, wre_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [15:0]     dto_q, dto_d;
    logic            f_ack_q, f_ack_d, g_ack_q, g_ack_d;
    logic [15:0]     f_dti_q, f_dti_d, g_dti_q, g_dti_d;

    logic            req_any, gnt_g_c, acc, cur_g, cur_wre;
    logic [AW-1:0]   cur_adr;
    logic [15:0]     cur_dto, ram_dout;
    logic            unused_adr_hi;

    // Upper address bits alias onto the RAM and are deliberately ignored.
    assign unused_adr_hi = ^{f_adr, g_adr};

    // Arbitration and RAM access selection: in IDLE the live bus feeds the RAM so
    // a zero-wait access completes at the sampling edge; otherwise latched fields.
    always_comb begin
        req_any = f_stb | g_stb;
        gnt_g_c = g_stb & (~f_stb | pref_g_q);
        cur_g   = gnt_g_q;
        cur_wre = wre_q;
        cur_adr = adr_q;
        cur_dto = dto_q;
        acc     = 1'b0;
        if (state_q == ST_IDLE) begin
            cur_g   = gnt_g_c;
            cur_wre = gnt_g_c ? g_wre : f_wre;
            cur_adr = gnt_g_c ? g_adr[AW-1:0] : f_adr[AW-1:0];
            cur_dto = gnt_g_c ? g_dto : f_dto;
            acc     = req_any && (WAIT == 0);
        end else if (state_q == ST_WAIT) begin
            acc     = (cnt_q == '0);
        end
    end

    // Next-state, latching of the granted request, ack and read-data updates.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pref_g_d = pref_g_q;
        gnt_g_d  = gnt_g_q;
        wre_d    = wre_q;
        adr_d    = adr_q;
        dto_d    = dto_q;
        f_ack_d  = 1'b0;
        g_ack_d  = 1'b0;
        f_dti_d  = f_dti_q;
        g_dti_d  = g_dti_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    gnt_g_d  = gnt_g_c;
                    pref_g_d = ~gnt_g_c;
                    wre_d    = cur_wre;
                    adr_d    = cur_adr;
                    dto_d    = cur_dto;
                    if (WAIT == 0) begin
                        state_d = ST_ACK;
                    end else begin
                        cnt_d   = CW'(WAIT - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                if (!wre_q) begin
                    if (gnt_g_q) begin
                        g_dti_d = ram_dout;
                    end else begin
                        f_dti_d = ram_dout;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (acc) begin
            f_ack_d = ~cur_g;
            g_ack_d = cur_g;
        end
    end

    // State registers; RAM contents are deliberately left out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pref_g_q <= 1'b0;
            gnt_g_q  <= 1'b0;
            wre_q    <= 1'b0;
            adr_q    <= '0;
            dto_q    <= '0;
            f_ack_q  <= 1'b0;
            g_ack_q  <= 1'b0;
            f_dti_q  <= '0;
            g_dti_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pref_g_q <= pref_g_d;
            gnt_g_q  <= gnt_g_d;
            wre_q    <= wre_d;
            adr_q    <= adr_d;
            dto_q    <= dto_d;
            f_ack_q  <= f_ack_d;
            g_ack_q  <= g_ack_d;
            f_dti_q  <= f_dti_d;
            g_dti_q  <= g_dti_d;
        end
    end

    dcpu16_spram #(.AW(AW)) u_ram (
        .clk  (clk),
        .en   (acc),
        .we   (cur_wre),
        .adr  (cur_adr),
        .din  (cur_dto),
        .dout (ram_dout)
    );

    // Ack is gated by the live strobe; read data is bypassed from the RAM during ACK.
    assign f_ack = f_ack_q & f_stb;
    assign g_ack = g_ack_q & g_stb;
    assign f_dti = (state_q == ST_ACK && !gnt_g_q && !wre_q) ? ram_dout : f_dti_q;
    assign g_dti = (state_q == ST_ACK &&  gnt_g_q && !wre_q) ? ram_dout : g_dti_q;

endmodule

// File: tb/tb_dcpu16_mslave.sv
// Self-checking bench: three responders (WAIT=0,2,3; AW=8) driven by queue-based
// initiators and compared against a transaction-level model.
module tb_dcpu16_mslave;

    localparam int N = 3;

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [15:0] dto;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]        rst_v, f_stb_v, f_wre_v, g_stb_v, g_wre_v;
    logic [N-1:0][15:0]  f_adr_v, f_dto_v, g_adr_v, g_dto_v;
    wire  [N-1:0]        f_ack_v, g_ack_v;
    wire  [N-1:0][15:0]  f_dti_v, g_dti_v;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        localparam int WT = (gi == 0) ? 0 : ((gi == 1) ? 2 : 3);
        dcpu16_mslave #(.AW(8), .WAIT(WT)) u_dut (
            .clk   (clk),
            .rst   (rst_v[gi]),
            .f_adr (f_adr_v[gi]),
            .f_stb (f_stb_v[gi]),
            .f_wre (f_wre_v[gi]),
            .f_dto (f_dto_v[gi]),
            .f_dti (f_dti_v[gi]),
            .f_ack (f_ack_v[gi]),
            .g_adr (g_adr_v[gi]),
            .g_stb (g_stb_v[gi]),
            .g_wre (g_wre_v[gi]),
            .g_dto (g_dto_v[gi]),
            .g_dti (g_dti_v[gi]),
            .g_ack (g_ack_v[gi])
        );
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          waits [N] = '{0, 2, 3};

    // Model: memory image (aliased on 8 bits), tie preference (1 = G next), dti values.
    logic [15:0] mmem   [N][256];
    bit          pref_g [N];
    logic [15:0] ef_dti [N];
    logic [15:0] eg_dti [N];

    req_t        fq[$];
    req_t        gq[$];
    int          last_f_stall, last_g_stall;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_req(input bit to_g, input logic we, input logic [15:0] adr, input logic [15:0] dto);
        req_t r;
        r.we  = we;
        r.adr = adr;
        r.dto = dto;
        if (to_g) gq.push_back(r);
        else      fq.push_back(r);
    endtask

    // Initiators present queue heads and hold them until ack; the model serves one
    // request at a time for WAIT+2 cycles, picking round-robin on ties.
    task automatic run_engine(input int k);
        int   busy, ack_at, c;
        bit   srv_g, exp_fa, exp_ga;
        req_t cur;
        busy = 0; ack_at = -1; c = 0; srv_g = 0;
        cur.we = 0; cur.adr = 0; cur.dto = 0;
        last_f_stall = 0; last_g_stall = 0;
        while ((fq.size() > 0 || gq.size() > 0 || busy > 0) && c < 3000) begin
            @(posedge clk); #1;
            f_stb_v[k] = (fq.size() > 0);
            g_stb_v[k] = (gq.size() > 0);
            if (fq.size() > 0) begin
                f_wre_v[k] = fq[0].we; f_adr_v[k] = fq[0].adr; f_dto_v[k] = fq[0].dto;
            end
            if (gq.size() > 0) begin
                g_wre_v[k] = gq[0].we; g_adr_v[k] = gq[0].adr; g_dto_v[k] = gq[0].dto;
            end
            if (busy == 0 && (fq.size() > 0 || gq.size() > 0)) begin
                srv_g     = (gq.size() > 0) && (fq.size() == 0 || pref_g[k]);
                cur       = srv_g ? gq[0] : fq[0];
                pref_g[k] = !srv_g;
                busy      = waits[k] + 2;
                ack_at    = c + waits[k] + 1;
            end
            @(negedge clk);
            exp_fa = (busy > 0) && (c == ack_at) && !srv_g;
            exp_ga = (busy > 0) && (c == ack_at) &&  srv_g;
            check_eq("f_ack", 32'(f_ack_v[k]), 32'(exp_fa));
            check_eq("g_ack", 32'(g_ack_v[k]), 32'(exp_ga));
            if (f_stb_v[k] && !f_ack_v[k]) last_f_stall++;
            if (g_stb_v[k] && !g_ack_v[k]) last_g_stall++;
            if (exp_fa || exp_ga) begin
                if (cur.we) mmem[k][cur.adr[7:0]] = cur.dto;
                else if (srv_g) eg_dti[k] = mmem[k][cur.adr[7:0]];
                else            ef_dti[k] = mmem[k][cur.adr[7:0]];
                $display("dut%0d %s %s adr=%h data=%h t=%0t", k, srv_g ? "G" : "F",
                         cur.we ? "WR" : "RD", cur.adr,
                         cur.we ? cur.dto : (srv_g ? eg_dti[k] : ef_dti[k]), $time);
                if (srv_g) void'(gq.pop_front());
                else       void'(fq.pop_front());
            end
            check_eq("f_dti", 32'(f_dti_v[k]), 32'(ef_dti[k]));
            check_eq("g_dti", 32'(g_dti_v[k]), 32'(eg_dti[k]));
            if (busy > 0) busy--;
            c++;
        end
        check_eq("queues_drained", 32'(fq.size() + gq.size()), 32'd0);
        fq.delete();
        gq.delete();
        @(posedge clk); #1;
        f_stb_v[k] = 1'b0;
        g_stb_v[k] = 1'b0;
    endtask

    initial begin
        rst_v = '0; f_stb_v = '0; f_wre_v = '0; g_stb_v = '0; g_wre_v = '0;
        f_adr_v = '0; f_dto_v = '0; g_adr_v = '0; g_dto_v = '0;
        for (int k = 0; k < N; k++) begin
            pref_g[k] = 0; ef_dti[k] = '0; eg_dti[k] = '0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check_eq("rst_f_ack", 32'(f_ack_v[k]), 32'd0);
            check_eq("rst_g_ack", 32'(g_ack_v[k]), 32'd0);
            check_eq("rst_f_dti", 32'(f_dti_v[k]), 32'd0);
            check_eq("rst_g_dti", 32'(g_dti_v[k]), 32'd0);
        end
        @(posedge clk); #3;
        rst_v = '1;

        // Fill every location with nonzero data so later reads have known values
        for (int k = 0; k < N; k++) begin
            for (int a = 0; a < 256; a++) push_req(0, 1'b1, 16'(a), 16'($urandom) | 16'h0001);
            run_engine(k);
        end

        // Single write then read, WAIT=0
        push_req(0, 1'b1, 16'h0010, 16'hBEEF);
        run_engine(0);
        push_req(1, 1'b0, 16'h0010, 16'h0000);
        run_engine(0);
        check_eq("wr_rd_beef", 32'(g_dti_v[0]), 32'h0000BEEF);

        // Aliasing, AW=8
        push_req(0, 1'b1, 16'h0105, 16'h5A5A);
        run_engine(0);
        push_req(0, 1'b0, 16'h0005, 16'h0000);
        run_engine(0);
        check_eq("alias", 32'(f_dti_v[0]), 32'h00005A5A);

        // Wait states, WAIT=2: G read stalls its initiator for 3 cycles
        push_req(1, 1'b0, 16'h0033, 16'h0000);
        run_engine(1);
        check_eq("g_stall", 32'(last_g_stall), 32'd3);
        check_eq("f_stall", 32'(last_f_stall), 32'd0);

        // Protocol guard: G write dropped mid-WAIT commits but is never acked
        @(posedge clk); #1;
        g_stb_v[1] = 1'b1; g_wre_v[1] = 1'b1; g_adr_v[1] = 16'h0020; g_dto_v[1] = 16'h1234;
        @(negedge clk);
        check_eq("guard_g_ack", 32'(g_ack_v[1]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("guard_g_ack", 32'(g_ack_v[1]), 32'd0);
        @(posedge clk); #1;
        g_stb_v[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("guard_g_ack", 32'(g_ack_v[1]), 32'd0);
            check_eq("guard_f_ack", 32'(f_ack_v[1]), 32'd0);
        end
        mmem[1][8'h20] = 16'h1234;
        pref_g[1] = 0;
        push_req(1, 1'b0, 16'h0020, 16'h0000);
        run_engine(1);
        check_eq("guard_readback", 32'(g_dti_v[1]), 32'h00001234);

        // Reset mid-WAIT (WAIT=3): load both dti registers first, then abort a read
        push_req(0, 1'b0, 16'h0041, 16'h0000);
        push_req(1, 1'b0, 16'h0042, 16'h0000);
        run_engine(2);
        @(posedge clk); #1;
        f_stb_v[2] = 1'b1; f_wre_v[2] = 1'b0; f_adr_v[2] = 16'h0043;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_v[2] = 1'b0;
        f_stb_v[2] = 1'b0;
        #1;
        check_eq("arst_f_ack", 32'(f_ack_v[2]), 32'd0);
        check_eq("arst_g_ack", 32'(g_ack_v[2]), 32'd0);
        check_eq("arst_f_dti", 32'(f_dti_v[2]), 32'd0);
        check_eq("arst_g_dti", 32'(g_dti_v[2]), 32'd0);
        @(posedge clk); #3;
        rst_v[2] = 1'b1;
        pref_g[2] = 0; ef_dti[2] = '0; eg_dti[2] = '0;
        push_req(0, 1'b0, 16'h0044, 16'h0000);
        run_engine(2);

        // Contention: both buses continuously requesting, 4 reads each
        for (int k = N - 1; k >= 0; k--) begin
            for (int i = 0; i < 4; i++) begin
                push_req(0, 1'b0, 16'($urandom), 16'h0000);
                push_req(1, 1'b0, 16'($urandom), 16'h0000);
            end
            run_engine(k);
        end

        // Random mixed traffic on both buses
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 40; i++) begin
                push_req(bit'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                         16'($urandom), 16'($urandom));
            end
            run_engine(k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
